// File: rtl/data_mem_if.sv
// -----------------------------------------------------------------------------
// data_mem_if
// Data-port bus between the single-cycle core and its data memory responder.
// There is no handshake. The core presents adr, wdata, mem_read and mem_write
// for exactly one cycle. A load is answered combinationally on rdata in that
// same cycle. A store commits at the rising clock edge that ends the cycle.
//   adr       : byte address (core data_adr)
//   wdata     : store data (core data_out)
//   rdata     : load data (core data_in)
//   mem_read  : load request
//   mem_write : store request
// -----------------------------------------------------------------------------
interface data_mem_if;
   logic [31:0] adr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        mem_read;
   logic        mem_write;

   modport master (output adr, output wdata, output mem_read, output mem_write,
                   input rdata);
   modport slave  (input adr, input wdata, input mem_read, input mem_write,
                   output rdata);
endinterface

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Memory-side responder for the single-cycle MIPS core's data port. It holds a
// word-addressed RAM and a 256-byte memory-mapped register window at MMIO_BASE.
// Registers (byte offsets from MMIO_BASE):
//   0x00 LED     RW
//   0x04 CYCLE   RO  free-running counter, wraps
//   0x08 CMP     RW
//   0x0C STATUS  W1C bit0 = misaligned access (sticky), bit1 = timer match (sticky)
//   0x10 WCOUNT  RO  committed RAM stores, saturating
// Ports:
//   clk            : rising-edge clock
//   rst            : asynchronous, active-high reset
//   bus            : data_mem_if slave (adr, wdata, rdata, mem_read, mem_write)
//   led_out        : LED register contents
//   timer_irq      : STATUS[1]
//   misaligned_err : STATUS[0]
// -----------------------------------------------------------------------------
module data_mem_responder #(
   parameter int          ADDR_W    = 10,
   parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
   input  logic         clk,
   input  logic         rst,
   data_mem_if.slave    bus,
   output logic [31:0]  led_out,
   output logic         timer_irq,
   output logic         misaligned_err
);

   localparam int          DEPTH      = 1 << ADDR_W;
   localparam logic [7:0]  OFF_LED    = 8'h00;
   localparam logic [7:0]  OFF_CYCLE  = 8'h04;
   localparam logic [7:0]  OFF_CMP    = 8'h08;
   localparam logic [7:0]  OFF_STATUS = 8'h0C;
   localparam logic [7:0]  OFF_WCOUNT = 8'h10;

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_led;
   logic [31:0] r_cycle;
   logic [31:0] r_cmp;
   logic [1:0]  r_status;
   logic [31:0] r_wcount;

   logic              w_aligned;
   logic              w_misaligned;
   logic              w_ram_hit;
   logic              w_mmio_hit;
   logic [ADDR_W-1:0] w_idx;
   logic [7:0]        w_off;
   logic              w_wr_ok;
   logic              w_ram_we;
   logic              w_mmio_we;
   logic              w_match;
   logic [1:0]        w_status_next;

   // Address decode
   assign w_aligned    = (bus.adr[1:0] == 2'b00);
   assign w_misaligned = (bus.mem_read | bus.mem_write) & ~w_aligned;
   assign w_ram_hit    = (bus.adr[31:ADDR_W+2] == '0);
   assign w_mmio_hit   = (bus.adr[31:8] == MMIO_BASE[31:8]);
   assign w_idx        = bus.adr[ADDR_W+1:2];
   assign w_off        = bus.adr[7:0];

   // A misaligned store is dropped whatever it targets.
   assign w_wr_ok   = bus.mem_write & w_aligned;
   // The RAM has no reset, so a store in flight while rst is high is gated here.
   assign w_ram_we  = w_wr_ok & w_ram_hit & ~rst;
   assign w_mmio_we = w_wr_ok & w_mmio_hit;

   // The compare uses the pre-edge CYCLE, so the flag sets at the edge that
   // ends the cycle in which CYCLE == CMP.
   assign w_match = (r_cmp != 32'h0) && (r_cycle == r_cmp);

   // The W1C clear is applied first and the set conditions after it, so a
   // set in the same cycle as a clear wins.
   always_comb begin
      w_status_next = r_status;
      if (w_mmio_we && (w_off == OFF_STATUS)) begin
         w_status_next = r_status & ~bus.wdata[1:0];
      end
      if (w_misaligned) begin
         w_status_next[0] = 1'b1;
      end
      if (w_match) begin
         w_status_next[1] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_ram_we) begin
         r_mem[w_idx] <= bus.wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_led    <= 32'h0;
         r_cycle  <= 32'h0;
         r_cmp    <= 32'h0;
         r_status <= 2'b00;
         r_wcount <= 32'h0;
      end else begin
         r_cycle  <= r_cycle + 32'h1;
         r_status <= w_status_next;
         if (w_mmio_we && (w_off == OFF_LED)) begin
            r_led <= bus.wdata;
         end
         if (w_mmio_we && (w_off == OFF_CMP)) begin
            r_cmp <= bus.wdata;
         end
         if (w_ram_we && (r_wcount != 32'hFFFF_FFFF)) begin
            r_wcount <= r_wcount + 32'h1;
         end
      end
   end

   // Combinational read path. It always shows pre-edge contents, so a load
   // in the same cycle as a store to that address returns the old value.
   always_comb begin
      bus.rdata = 32'h0;
      if (bus.mem_read && w_aligned) begin
         if (w_ram_hit) begin
            bus.rdata = r_mem[w_idx];
         end else if (w_mmio_hit) begin
            case (w_off)
               OFF_LED:    bus.rdata = r_led;
               OFF_CYCLE:  bus.rdata = r_cycle;
               OFF_CMP:    bus.rdata = r_cmp;
               OFF_STATUS: bus.rdata = {30'h0, r_status};
               OFF_WCOUNT: bus.rdata = r_wcount;
               default:    bus.rdata = 32'h0;
            endcase
         end
      end
   end

   assign led_out        = r_led;
   assign timer_irq      = r_status[1];
   assign misaligned_err = r_status[0];

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
   localparam logic [31:0] BASE = 32'hFFFF_FF00;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   data_mem_if bus ();
   logic [31:0] led_out;
   logic        timer_irq;
   logic        misaligned_err;

   data_mem_responder #(.ADDR_W(10), .MMIO_BASE(BASE)) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .led_out        (led_out),
      .timer_irq      (timer_irq),
      .misaligned_err (misaligned_err)
   );

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: state after the most recent clock edge.
   logic [31:0] m_led, m_cycle, m_cmp, m_wcount;
   logic [1:0]  m_status;
   logic [31:0] m_mem [1024];
   bit          m_val [1024];

   task automatic model_reset();
      m_led = 0; m_cycle = 0; m_cmp = 0; m_wcount = 0; m_status = 0;
   endtask

   function automatic bit model_read(input logic [31:0] a, input logic rd, output logic [31:0] v);
      v = 32'h0;
      if (!rd || (a % 4 != 0)) return 1'b1;
      if (a < 4096) begin
         v = m_mem[a / 4];
         return m_val[a / 4];
      end
      if (a >= BASE) begin
         case (a - BASE)
            0:       v = m_led;
            4:       v = m_cycle;
            8:       v = m_cmp;
            12:      v = {30'h0, m_status};
            16:      v = m_wcount;
            default: v = 32'h0;
         endcase
      end
      return 1'b1;
   endfunction

   task automatic model_step(input logic [31:0] a, input logic [31:0] wd, input logic rd, input logic wr);
      bit         mis;
      bit         store;
      bit         match;
      logic [1:0] st;
      mis   = (rd || wr) && (a % 4 != 0);
      store = wr && !mis;
      match = (m_cmp != 0) && (m_cycle == m_cmp);
      st    = m_status;
      if (store && a < 4096) begin
         m_mem[a / 4] = wd;
         m_val[a / 4] = 1'b1;
         if (m_wcount != 32'hFFFF_FFFF) m_wcount = m_wcount + 1;
      end
      if (store && a == BASE)      m_led = wd;
      if (store && a == BASE + 8)  m_cmp = wd;
      if (store && a == BASE + 12) st = st & ~wd[1:0];
      if (mis)   st[0] = 1'b1;
      if (match) st[1] = 1'b1;
      m_status = st;
      m_cycle  = m_cycle + 1;
   endtask

   // Compare process: every cycle, mid-cycle, outputs versus the model.
   always @(negedge clk) begin
      logic [31:0] ev;
      bit          known;
      if (rst) begin
         check("rst_led", led_out, 32'h0);
         check("rst_irq", {31'h0, timer_irq}, 32'h0);
         check("rst_err", {31'h0, misaligned_err}, 32'h0);
         model_reset();
      end else begin
         known = model_read(bus.adr, bus.mem_read, ev);
         if (known) check("rdata", bus.rdata, ev);
         check("led_out", led_out, m_led);
         check("timer_irq", {31'h0, timer_irq}, {31'h0, m_status[1]});
         check("misaligned_err", {31'h0, misaligned_err}, {31'h0, m_status[0]});
         model_step(bus.adr, bus.wdata, bus.mem_read, bus.mem_write);
      end
   end

   // Driver tasks
   task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic rd, input logic wr);
      @(posedge clk);
      #1;
      bus.adr = a; bus.wdata = wd; bus.mem_read = rd; bus.mem_write = wr;
   endtask

   task automatic nop();
      drive(32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic at_neg();
      @(negedge clk);
      #1;
   endtask

   logic [31:0] c;
   logic [31:0] a;
   logic [31:0] vals [1024];

   initial begin
      bus.adr = 0; bus.wdata = 0; bus.mem_read = 0; bus.mem_write = 0;
      model_reset();
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Store then load; same-cycle load returns the prior contents.
      drive(32'h10, 32'hAAAA_5555, 1'b0, 1'b1);
      drive(32'h10, 32'h1234_5678, 1'b1, 1'b1);
      at_neg(); check("rdw_old", bus.rdata, 32'hAAAA_5555);
      drive(32'h10, 32'h0, 1'b1, 1'b0);
      at_neg(); check("ld_new", bus.rdata, 32'h1234_5678);
      drive(BASE + 16, 32'h0, 1'b1, 1'b0);
      at_neg(); check("wcount2", bus.rdata, 32'd2);

      // Misaligned store, then W1C of STATUS[0].
      drive(32'h12, 32'hDEAD_BEEF, 1'b0, 1'b1);
      drive(32'h10, 32'h0, 1'b1, 1'b0);
      at_neg(); check("mis_ram", bus.rdata, 32'h1234_5678);
      check("mis_err", {31'h0, misaligned_err}, 32'h1);
      drive(BASE + 12, 32'h1, 1'b0, 1'b1);
      at_neg(); check("w1c_pre", {31'h0, misaligned_err}, 32'h1);
      nop();
      at_neg(); check("w1c_post", {31'h0, misaligned_err}, 32'h0);

      // Timer match with a colliding W1C.
      nop();
      c = m_cycle + 7;
      drive(BASE + 8, c, 1'b0, 1'b1);
      repeat (5) nop();
      drive(BASE + 12, 32'h2, 1'b0, 1'b1);
      at_neg(); check("irq_pre", {31'h0, timer_irq}, 32'h0);
      drive(BASE + 12, 32'h2, 1'b0, 1'b1);
      at_neg(); check("irq_setwins", {31'h0, timer_irq}, 32'h1);
      nop();
      at_neg(); check("irq_clr", {31'h0, timer_irq}, 32'h0);

      // LED, read-only CYCLE, reserved offset, unmapped store.
      drive(BASE, 32'hA5, 1'b0, 1'b1);
      drive(BASE + 4, 32'h5555_5555, 1'b0, 1'b1);
      at_neg(); check("led", led_out, 32'hA5);
      drive(BASE + 32'h20, 32'h0, 1'b1, 1'b0);
      at_neg(); check("reserved", bus.rdata, 32'h0);
      drive(32'h8000_0000, 32'h77, 1'b0, 1'b1);
      drive(BASE + 16, 32'h0, 1'b1, 1'b0);
      at_neg(); check("wcount_unmapped", bus.rdata, 32'd2);

      // CYCLE wrap, reached by forcing the counter.
      drive(BASE + 4, 32'h0, 1'b1, 1'b0);
      force dut.r_cycle = 32'hFFFF_FFFE;
      #1 release dut.r_cycle;
      m_cycle = 32'hFFFF_FFFE;
      at_neg(); check("cyc_fe", bus.rdata, 32'hFFFF_FFFE);
      drive(BASE + 4, 32'h0, 1'b1, 1'b0);
      at_neg(); check("cyc_ff", bus.rdata, 32'hFFFF_FFFF);
      drive(BASE + 4, 32'h0, 1'b1, 1'b0);
      at_neg(); check("cyc_wrap", bus.rdata, 32'h0);

      // Randomized traffic across RAM, MMIO, misaligned and unmapped space.
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0: a = 32'($urandom_range(0, 1023)) * 4;
            1: a = 32'($urandom_range(0, 1023)) * 4 + 32'($urandom_range(1, 3));
            2: a = BASE + 32'($urandom_range(0, 9)) * 4;
            default: a = 32'h8000_0000 + 32'($urandom_range(0, 255)) * 4;
         endcase
         drive(a, $urandom(), 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)));
      end

      // Asynchronous reset mid-cycle, with a store in flight.
      drive(32'h10, 32'h5555_0000, 1'b0, 1'b1);
      drive(BASE, 32'hFFFF_0001, 1'b0, 1'b1);
      drive(32'h10, 32'hBAD0_BAD0, 1'b0, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("arst_led", led_out, 32'h0);
      check("arst_irq", {31'h0, timer_irq}, 32'h0);
      check("arst_err", {31'h0, misaligned_err}, 32'h0);
      @(posedge clk);
      #1;
      bus.mem_write = 1'b0;
      rst = 1'b0;
      drive(32'h10, 32'h0, 1'b1, 1'b0);
      at_neg(); check("rst_store_dropped", bus.rdata, 32'h5555_0000);

      // Fill every RAM word, then read it all back.
      for (int i = 0; i < 1024; i++) begin
         vals[i] = $urandom();
         drive(32'(i) * 4, vals[i], 1'b0, 1'b1);
      end
      for (int i = 0; i < 1024; i++) begin
         drive(32'(i) * 4, 32'h0, 1'b1, 1'b0);
         if (i % 128 == 0) begin
            at_neg(); check("fill_word", bus.rdata, vals[i]);
         end
      end
      drive(BASE + 16, 32'h0, 1'b1, 1'b0);
      at_neg(); check("wcount1024", bus.rdata, 32'd1024);

      nop();
      nop();
      @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
